bus_decode_ctrl: RTL and testbench
==================================

// Module: bus_decode_ctrl
// PURPOSE
//  Parametrised memory-map decoder and access sequencer between the CPU data port and NUM_DEV peripherals.
//  Decodes the top REGION_W address bits into a device index, then drives a one-hot select and strobe.
//  Waits for that device's ack, or for a timeout, and returns a one-cycle ready with rdata or err.
//  Successor to the combinational rd/wr/addr -> hit/did decoder: adds a handshake, timeout, error status and error count.
// PARAMETERS
//  ADDR_W    16  CPU address width
//  DATA_W    16  data width
//  REGION_W  4   top address bits selecting a region; region r maps to device r
//  NUM_DEV   7   implemented devices, 1..2**REGION_W-1; regions >= NUM_DEV are unmapped
//  TIMEOUT   15  max cycles waiting for dev_ack; 0 = wait forever
//  ERR_DATA  16'hDEAD  rdata returned on any error
//  ERR_CNT_W 8   width of the saturating error counter
//  (derived) DID_W = $clog2(NUM_DEV+1); OFFS_W = ADDR_W-REGION_W
// PORTS
//  clk        in   1                clock, rising edge
//  rst        in   1                asynchronous reset, active-high
//  rd         in   1                CPU read request, held until ready
//  wr         in   1                CPU write request, held until ready
//  addr       in   ADDR_W           CPU address, held until ready
//  wdata      in   DATA_W           CPU write data, held until ready
//  ready      out  1                one-cycle completion pulse
//  rdata      out  DATA_W           read data, valid with ready
//  err        out  1                error flag, valid with ready (unmapped region or timeout)
//  hit        out  1                last accepted request mapped to a device
//  did        out  DID_W            device index of last accepted request; NUM_DEV if unmapped
//  err_cnt    out  ERR_CNT_W        saturating count of error completions
//  dev_sel    out  NUM_DEV          one-hot device select
//  dev_rd     out  1                read strobe to the selected device
//  dev_wr     out  1                write strobe to the selected device
//  dev_addr   out  OFFS_W           offset within the region (addr[OFFS_W-1:0])
//  dev_wdata  out  DATA_W           write data to the device
//  dev_rdata  in   NUM_DEV*DATA_W   per-device read data; device i at [i*DATA_W +: DATA_W]
//  dev_ack    in   NUM_DEV          per-device completion
// BEHAVIOUR
//  Reset (async): state=IDLE; ready=0, err=0, rdata=0, hit=0, did=0, err_cnt=0, dev_sel=0, dev_rd=dev_wr=0.
//    Reset mid-access drops all strobes immediately; the access is abandoned with no ready.
//  FSM IDLE -> ACCESS -> RESP -> IDLE, or IDLE -> RESP on an unmapped region.
//  IDLE: samples (rd|wr) at a rising edge and latches addr/wdata/op. rd&wr together is a write; rd is ignored.
//    region = addr[ADDR_W-1 -: REGION_W].
//    region < NUM_DEV: hit=1, did=region, go to ACCESS.
//    Otherwise: hit=0, did=NUM_DEV, go to RESP with err=1 and rdata=ERR_DATA; no device is strobed.
//  ACCESS: dev_sel[did]=1, dev_rd/dev_wr per op; dev_addr and dev_wdata come from the latches.
//    A timer clears on entry and increments every cycle.
//    dev_ack[did]=1 at an edge: capture dev_rdata slice (zero for writes), err=0, go to RESP.
//    dev_ack from non-selected devices is ignored.
//    TIMEOUT!=0 and timer==TIMEOUT-1 with no ack: err=1, rdata=ERR_DATA, go to RESP.
//    Ack and timeout on the same edge: ack wins.
//  RESP: strobes low, ready=1 for exactly one cycle, then IDLE. rd/wr are not sampled in RESP.
//    rdata/err hold until the next accept.
//  Latency, counted from the accept edge to the cycle ready is high:
//    unmapped: ready in the cycle after the accept edge;
//    mapped: 1 + N cycles, where N = cycles strobes were high (min 2).
//  Back-to-back: at least one IDLE cycle separates transactions.
//  err_cnt increments on each err completion and saturates at all-ones.
//  hit/did are registered and update only on accept.
// TESTING
//  Reset, then rd at 16'h1ABC, dev 1 acks on its 2nd strobe cycle with 16'h1234 -> dev_sel=7'b0000010, dev_addr=12'hABC, ready with rdata=16'h1234, err=0, did=1, hit=1.
//  wr at 16'h6FFF, wdata=16'h55AA, dev 6 acks in its 1st cycle -> dev_wr=1, dev_sel[6]=1, dev_wdata=16'h55AA, ready 2 cycles after accept, err=0.
//  rd at 16'h7000 -> no dev_sel, ready 1 cycle after accept, err=1, rdata=16'hDEAD, hit=0, did=7, err_cnt=1.
//  rd at 16'h2000 with no ack -> strobes held 15 cycles, then ready with err=1 and rdata=16'hDEAD; dev_ack[3] pulses during the wait are ignored.
//  rd&wr at 16'h4000 -> write to dev 4, dev_rd=0. Separately, assert rst during ACCESS -> all outputs 0 immediately, no ready.
//  300 consecutive unmapped requests -> err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/bus_decode_ctrl.sv
// Memory-map decoder and access sequencer between the CPU data port and NUM_DEV peripherals.
// Decodes the top address bits to a device, strobes it, and waits for its ack or a timeout.
module bus_decode_ctrl #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter int                REGION_W  = 4,
    parameter int                NUM_DEV   = 7,
    parameter int                TIMEOUT   = 15,
    parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(16'hDEAD),
    parameter int                ERR_CNT_W = 8,
    localparam int               DID_W     = $clog2(NUM_DEV + 1),
    localparam int               OFFS_W    = ADDR_W - REGION_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd,
    input  logic                        wr,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    output logic                        ready,
    output logic [DATA_W-1:0]           rdata,
    output logic                        err,
    output logic                        hit,
    output logic [DID_W-1:0]            did,
    output logic [ERR_CNT_W-1:0]        err_cnt,
    output logic [NUM_DEV-1:0]          dev_sel,
    output logic                        dev_rd,
    output logic                        dev_wr,
    output logic [OFFS_W-1:0]           dev_addr,
    output logic [DATA_W-1:0]           dev_wdata,
    input  logic [NUM_DEV*DATA_W-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]          dev_ack
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    logic                op_wr;
    logic [OFFS_W-1:0]   offs_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [TMR_W-1:0]    timer;

    logic [REGION_W-1:0] region;
    logic                region_hit;
    logic                ack_sel;
    logic [DATA_W-1:0]   rdata_sel;
    logic                timeout_hit;

    assign region      = addr[ADDR_W-1 -: REGION_W];
    assign region_hit  = (region < REGION_W'(NUM_DEV));
    assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1));
    assign dev_addr    = offs_q;
    assign dev_wdata   = wdata_q;

    // Ack and read data are steered by the registered one-hot select, so
    // acks from devices that are not being accessed never reach the FSM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (dev_sel[i]) begin
                ack_sel   = ack_sel | dev_ack[i];
                rdata_sel = rdata_sel | dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_wr   <= 1'b0;
            offs_q  <= '0;
            wdata_q <= '0;
            timer   <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            hit     <= 1'b0;
            did     <= '0;
            err_cnt <= '0;
            dev_sel <= '0;
            dev_rd  <= 1'b0;
            dev_wr  <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd | wr) begin
                        offs_q  <= addr[OFFS_W-1:0];
                        wdata_q <= wdata;
                        op_wr   <= wr;
                        timer   <= '0;
                        if (region_hit) begin
                            hit     <= 1'b1;
                            did     <= DID_W'(region);
                            dev_sel <= NUM_DEV'(1) << region;
                            dev_rd  <= ~wr;
                            dev_wr  <= wr;
                            state   <= ACCESS;
                        end else begin
                            hit     <= 1'b0;
                            did     <= DID_W'(NUM_DEV);
                            ready   <= 1'b1;
                            err     <= 1'b1;
                            rdata   <= ERR_DATA;
                            err_cnt <= sat_inc(err_cnt);
                            state   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_sel) begin
                        dev_sel <= '0;
                        dev_rd  <= 1'b0;
                        dev_wr  <= 1'b0;
                        ready   <= 1'b1;
                        err     <= 1'b0;
                        rdata   <= op_wr ? '0 : rdata_sel;
                        state   <= RESP;
                    end else if (timeout_hit) begin
                        dev_sel <= '0;
                        dev_rd  <= 1'b0;
                        dev_wr  <= 1'b0;
                        ready   <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= ERR_DATA;
                        err_cnt <= sat_inc(err_cnt);
                        state   <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_decode_ctrl.sv
// Directed bench for bus_decode_ctrl: a transaction-level model predicts strobes, latency and
// completion status; a negedge compare process checks the DUT against it every cycle.
module tb_bus_decode_ctrl;

    localparam int TIMEOUT = 15;
    localparam int NDEV    = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd, wr;
    logic [15:0]  addr, wdata;
    logic         ready;
    logic [15:0]  rdata;
    logic         err, hit;
    logic [2:0]   did;
    logic [7:0]   err_cnt;
    logic [6:0]   dev_sel;
    logic         dev_rd, dev_wr;
    logic [11:0]  dev_addr;
    logic [15:0]  dev_wdata;
    logic [111:0] dev_rdata;
    logic [6:0]   dev_ack;

    bus_decode_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .err       (err),
        .hit       (hit),
        .did       (did),
        .err_cnt   (err_cnt),
        .dev_sel   (dev_sel),
        .dev_rd    (dev_rd),
        .dev_wr    (dev_wr),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Model expectations for the current cycle.
    bit          chk_en = 1'b0;
    logic        exp_ready, exp_rd, exp_wr, exp_err, exp_hit;
    logic [6:0]  exp_sel;
    logic [11:0] exp_addr;
    logic [15:0] exp_wdata, exp_rdata;
    logic [2:0]  exp_did;
    logic [7:0]  exp_cnt;
    int          model_errs = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",   ready,   exp_ready);
            check("dev_sel", dev_sel, exp_sel);
            check("dev_rd",  dev_rd,  exp_rd);
            check("dev_wr",  dev_wr,  exp_wr);
            if (exp_sel != 0) begin
                check("dev_addr",  dev_addr,  exp_addr);
                check("dev_wdata", dev_wdata, exp_wdata);
            end
            check("rdata",   rdata,   exp_rdata);
            check("err",     err,     exp_err);
            check("hit",     hit,     exp_hit);
            check("did",     did,     exp_did);
            check("err_cnt", err_cnt, exp_cnt);
        end
    end

    task automatic clear_model();
        exp_ready = 0; exp_rd = 0; exp_wr = 0; exp_err = 0; exp_hit = 0;
        exp_sel = '0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        exp_did = '0; exp_cnt = '0; model_errs = 0;
    endtask

    // One CPU transaction, started in an IDLE cycle at posedge+1. ack_cyc is the
    // strobe cycle (1-based) in which the device acks; 0 means it never acks.
    task automatic run_txn(input logic r, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input int ack_cyc,
                           input logic [15:0] ack_data, input bit noise,
                           output int lat, output logic [6:0] sel_seen,
                           output logic [11:0] offs_seen);
        logic [3:0]  region;
        bit          mapped, timed_out;
        int          n;
        logic [15:0] res_data;
        logic        res_err;

        region    = a[15:12];
        mapped    = (int'(region) < NDEV);
        timed_out = mapped && !(ack_cyc >= 1 && ack_cyc <= TIMEOUT);
        n         = !mapped ? 0 : (timed_out ? TIMEOUT : ack_cyc);
        res_err   = !mapped || timed_out;
        res_data  = res_err ? 16'hDEAD : (w ? 16'h0000 : ack_data);

        for (int i = 0; i < NDEV; i++) dev_rdata[i*16 +: 16] = 16'hA000 + 16'(i * 16'h0111);
        if (mapped) dev_rdata[int'(region)*16 +: 16] = ack_data;

        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        exp_hit   = mapped;
        exp_did   = mapped ? region[2:0] : 3'd7;
        lat       = 0;
        sel_seen  = dev_sel;
        offs_seen = dev_addr;
        for (int k = 1; k <= n; k++) begin
            exp_sel   = 7'(1) << region;
            exp_rd    = !w;
            exp_wr    = w;
            exp_addr  = a[11:0];
            exp_wdata = d;
            dev_ack   = '0;
            if (k == ack_cyc) dev_ack[region[2:0]] = 1'b1;
            if (noise && (k % 2 == 1)) dev_ack[3] = 1'b1;
            if (ready === 1'b1 && lat == 0) lat = k;
            @(posedge clk); #1;
        end
        dev_ack = '0;
        rd = 0; wr = 0;
        exp_sel = '0; exp_rd = 0; exp_wr = 0;
        exp_ready = 1'b1;
        exp_rdata = res_data;
        exp_err   = res_err;
        if (res_err) model_errs++;
        exp_cnt = (model_errs > 255) ? 8'hFF : 8'(model_errs);
        if (ready === 1'b1 && lat == 0) lat = n + 1;
        @(posedge clk); #1;
        exp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [6:0]  sel_seen;
        logic [11:0] offs_seen;

        rst = 1'b1; rd = 0; wr = 0; addr = '0; wdata = '0;
        dev_ack = '0; dev_rdata = '0;
        clear_model();
        #12;
        check("rst_ready",   ready,   1'b0);
        check("rst_outputs", {rdata, err, hit, did, err_cnt, dev_sel, dev_rd, dev_wr}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Read from device 1, ack on the 2nd strobe cycle.
        run_txn(1, 0, 16'h1ABC, 16'h0000, 2, 16'h1234, 0, lat, sel_seen, offs_seen);
        check("t1_sel",   sel_seen,  7'b0000010);
        check("t1_offs",  offs_seen, 12'hABC);
        check("t1_lat",   lat,       3);
        check("t1_rdata", rdata,     16'h1234);
        check("t1_hit_did", {hit, did}, {1'b1, 3'd1});

        // Write to device 6, ack in the 1st strobe cycle.
        run_txn(0, 1, 16'h6FFF, 16'h55AA, 1, 16'h9999, 0, lat, sel_seen, offs_seen);
        check("t2_sel",  sel_seen, 7'b1000000);
        check("t2_lat",  lat,      2);
        check("t2_err",  err,      1'b0);
        check("t2_rdata", rdata,   16'h0000);

        // Unmapped region 7.
        run_txn(1, 0, 16'h7000, 16'h0000, 1, 16'h1111, 0, lat, sel_seen, offs_seen);
        check("t3_sel",   sel_seen, 7'b0000000);
        check("t3_lat",   lat,      1);
        check("t3_rdata", rdata,    16'hDEAD);
        check("t3_status", {err, hit, did, err_cnt}, {1'b1, 1'b0, 3'd7, 8'd1});

        // Device 2 never acks; dev_ack[3] chatter must be ignored.
        run_txn(1, 0, 16'h2000, 16'h0000, 0, 16'h4444, 1, lat, sel_seen, offs_seen);
        check("t4_lat",   lat,     16);
        check("t4_rdata", rdata,   16'hDEAD);
        check("t4_cnt",   err_cnt, 8'd2);

        // rd and wr together is a write to device 4.
        run_txn(1, 1, 16'h4000, 16'h0F0F, 3, 16'hBEEF, 0, lat, sel_seen, offs_seen);
        check("t5_sel",   sel_seen, 7'b0010000);
        check("t5_lat",   lat,      4);
        check("t5_rdata", rdata,    16'h0000);

        // Ack on the very cycle the timeout would fire: ack wins.
        run_txn(1, 0, 16'h3123, 16'h0000, TIMEOUT, 16'h7777, 0, lat, sel_seen, offs_seen);
        check("t6_lat",   lat,     16);
        check("t6_rdata", rdata,   16'h7777);
        check("t6_err",   err,     1'b0);

        // Asynchronous reset in the middle of an access.
        chk_en = 1'b0;
        rd = 1; addr = 16'h5010; wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_sel", dev_sel, 7'b0100000);
        #2 rst = 1'b1;
        #1;
        check("mid_rst", {ready, rdata, err, hit, did, err_cnt, dev_sel, dev_rd, dev_wr}, '0);
        rd = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        chk_en = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Many unmapped requests across regions 7..15 saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            run_txn(1, 0, {4'(7 + i % 9), 12'(i)}, 16'h0000, 1, 16'h0000, 0,
                    lat, sel_seen, offs_seen);
        end
        check("sat_cnt", err_cnt, 8'hFF);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
